// File: rtl/mix_columns_engine_if.sv
// ============================================================================
// mix_columns_engine_if : valid/ready bus for the MixColumns engine
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mix_columns_engine_if;
  logic         in_valid;
  logic         in_ready;
  logic         inv;
  logic [127:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;

  modport master (
    output in_valid, inv, data_in, out_ready,
    input  in_ready, out_valid, data_out
  );

  modport slave (
    input  in_valid, inv, data_in, out_ready,
    output in_ready, out_valid, data_out
  );
endinterface

`default_nettype wire

// File: rtl/mix_columns_engine.sv
// ============================================================================
// mix_columns_engine : AES MixColumns / InvMixColumns, COLS_PER_CYCLE columns per beat
// Revision: 1.0
// ============================================================================
`default_nettype none

module mix_columns_engine #(
  parameter int COLS_PER_CYCLE = 4,
  parameter bit SUPPORT_INV    = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  mix_columns_engine_if.slave bus
);

  localparam int NBEATS = 4 / COLS_PER_CYCLE;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Inverse coefficients are built from xtime powers: 09=8+1, 0b=8+2+1, 0d=8+4+1, 0e=8+4+2.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv_mode);
    logic [7:0]  a  [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [31:0] res;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[(3-r)*8 +: 8];
      x2[r] = xtime(a[r]);
      x4[r] = xtime(x2[r]);
      x8[r] = xtime(x4[r]);
    end
    for (int r = 0; r < 4; r++) begin
      if (inv_mode) begin
        res[(3-r)*8 +: 8] = (x8[r] ^ x4[r] ^ x2[r])
                          ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])
                          ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])
                          ^ (x8[(r+3)%4] ^ a[(r+3)%4]);
      end else begin
        res[(3-r)*8 +: 8] = x2[r]
                          ^ (x2[(r+1)%4] ^ a[(r+1)%4])
                          ^ a[(r+2)%4]
                          ^ a[(r+3)%4];
      end
    end
    return res;
  endfunction

  state_t              state_q, state_d;
  logic [127:0]        work_q, work_d;
  logic                inv_q, inv_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready;
  logic                accept;
  logic [1:0]          col_idx [COLS_PER_CYCLE];
  logic [31:0]         col_out [COLS_PER_CYCLE];
  logic [127:0]        merged_work;

  assign in_ready = (state_q == ST_IDLE) | ((state_q == ST_DONE) & bus.out_ready);
  assign accept   = bus.in_valid & in_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = work_q;

  // Beat b handles columns 3-b*C down to 3-b*C-(C-1); column 3 is the first AES column.
  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    logic [1:0] idx;
    assign idx        = 2'(3 - (int'(beat_cnt_q) * COLS_PER_CYCLE + k));
    assign col_idx[k] = idx;
    assign col_out[k] = mix_col(work_q[idx*32 +: 32], inv_q);
  end

  always_comb begin
    merged_work = work_q;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      merged_work[col_idx[k]*32 +: 32] = col_out[k];
    end
  end

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    inv_d       = inv_q;
    beat_cnt_d  = beat_cnt_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_BUSY: begin
        work_d = merged_work;
        if (beat_cnt_q == BEAT_W'(NBEATS - 1)) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
        end else begin
          beat_cnt_d = BEAT_W'(beat_cnt_q + 1'b1);
        end
      end
      ST_IDLE, ST_DONE: begin
        if (state_q == ST_DONE && bus.out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
        // Accept can coincide with the output handshake in DONE.
        if (accept) begin
          state_d     = ST_BUSY;
          work_d      = bus.data_in;
          inv_d       = bus.inv & SUPPORT_INV;
          beat_cnt_d  = '0;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      work_q      <= '0;
      inv_q       <= 1'b0;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      inv_q       <= inv_d;
      beat_cnt_q  <= beat_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

`default_nettype wire
